// File: rtl/fft_frame_loader_pkg.sv
// atlas_pkg: shared loader FSM states and frame-length constants.
package atlas_pkg;

    localparam int N_2 = 5;
    localparam int N = 2 ** N_2;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} loader_state_t;

endpackage

// File: rtl/fft_frame_loader_sample_ram.sv
// sample_ram: ping-pong sample store, one write port and one registered read port.
module sample_ram #(
    parameter int width = 16,
    parameter int aw = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic             re,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] q
);

    logic [width-1:0] mem [0:2**aw-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output is forced to zero on cycles without a read so it doubles as the masked rd bus.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else q <= re ? mem[raddr] : '0;
    end

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs truncated i2s samples into ping-pong frames and streams them to the fft.
module fft_frame_loader
    import atlas_pkg::*;
#(
    parameter int width = 16,
    parameter int N_2 = atlas_pkg::N_2,
    parameter int in_width = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [in_width-1:0] left,
    input  logic                fft_done,
    output logic                load,
    output logic [width-1:0]    rd,
    output logic                start,
    output logic                busy,
    output logic                overrun
);

    loader_state_t state, state_n;
    logic wr_bank, rd_bank, rd_bank_n, sel_bank;
    logic [N_2-1:0] wr_ptr, rd_ptr, rd_ptr_n, rd_ptr_inc;
    logic [1:0] ready, ready_clr, ready_kept, ready_n;
    logic load_n, start_n, re, enter, frame_end, accept;
    logic [N_2:0] raddr;
    logic unused_lsbs;

    assign unused_lsbs = ^left[in_width-width-1:0];
    assign busy = state != IDLE;
    assign rd_ptr_inc = rd_ptr + N_2'(1);
    assign sel_bank = ~ready[0];
    assign enter = |ready && (state == IDLE || (state == WAIT_LO && !fft_done));
    // A ready-clear on the last load cycle is visible to a frame completing in the same cycle.
    assign ready_kept = ready & ~ready_clr;
    assign frame_end = sample_valid && wr_ptr == '1;
    assign accept = frame_end && !ready_kept[~wr_bank];
    assign ready_n = ready_kept | ({wr_bank, ~wr_bank} & {2{accept}});

    always_comb begin
        state_n = state;
        rd_bank_n = rd_bank;
        rd_ptr_n = rd_ptr;
        load_n = 1'b0;
        start_n = 1'b0;
        re = 1'b0;
        raddr = {rd_bank, rd_ptr_inc};
        ready_clr = 2'b00;
        case (state)
            LOAD: begin
                rd_ptr_n = rd_ptr_inc;
                if (rd_ptr == '1) begin
                    ready_clr = rd_bank ? 2'b10 : 2'b01;
                    start_n = 1'b1;
                    state_n = START;
                end else begin
                    re = 1'b1;
                    load_n = 1'b1;
                end
            end
            START: state_n = WAIT_HI;
            WAIT_HI: state_n = fft_done ? WAIT_LO : WAIT_HI;
            WAIT_LO: state_n = fft_done ? WAIT_LO : IDLE;
            default: state_n = IDLE;
        endcase
        // Issue the first read one cycle ahead so load and rd line up on the first load cycle.
        if (enter) begin
            state_n = LOAD;
            rd_bank_n = sel_bank;
            rd_ptr_n = '0;
            re = 1'b1;
            raddr = {sel_bank, {N_2{1'b0}}};
            load_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wr_bank <= 1'b0;
            wr_ptr <= '0;
            ready <= 2'b00;
            rd_bank <= 1'b0;
            rd_ptr <= '0;
            load <= 1'b0;
            start <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            rd_bank <= rd_bank_n;
            rd_ptr <= rd_ptr_n;
            ready <= ready_n;
            load <= load_n;
            start <= start_n;
            if (sample_valid) wr_ptr <= wr_ptr + N_2'(1);
            if (accept) wr_bank <= ~wr_bank;
            if (frame_end && !accept) overrun <= 1'b1;
        end
    end

    sample_ram #(.width(width), .aw(N_2 + 1)) u_ram (
        .clk(clk),
        .reset(reset),
        .we(sample_valid),
        .waddr({wr_bank, wr_ptr}),
        .wdata(left[in_width-1 -: width]),
        .re(re),
        .raddr(raddr),
        .q(rd)
    );

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench for frame packing, fft handshake, back-to-back and overrun.
module tb_fft_frame_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_valid = 1'b0;
    logic [23:0] left = '0;
    logic fft_done = 1'b0;
    logic load, start, busy, overrun;
    logic [15:0] rd;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_cnt++;

    fft_frame_loader dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .left(left),
        .fft_done(fft_done),
        .load(load),
        .rd(rd),
        .start(start),
        .busy(busy),
        .overrun(overrun)
    );

    task automatic send(input logic [23:0] v, input logic [15:0] e, input bit push, input int gap);
        @(posedge clk);
        #1 sample_valid = 1'b1;
        left = v;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        repeat (gap - 1) @(posedge clk);
    endtask

    // Must be called at a negedge; pops one scoreboard entry per load cycle.
    task automatic collect_frame(input string name);
        int w;
        logic [15:0] e;
        int s0;
        w = 0;
        while (load !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (load !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_load: load=%b never rose, required 1", name, load);
            return;
        end
        s0 = start_cnt;
        for (int i = 0; i < 32; i++) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
            checks++;
            if (load !== 1'b1 || rd !== e) begin
                errors++;
                $display("FAIL %s_data[%0d]: load=%b rd=%h, required load=1 rd=%h", name, i, load, rd, e);
            end
            @(negedge clk);
        end
        checks++;
        if (load !== 1'b0 || start !== 1'b1 || rd !== 16'h0) begin
            errors++;
            $display("FAIL %s_start: load=%b start=%b rd=%h, required 0 1 0000", name, load, start, rd);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || busy !== 1'b1 || start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL %s_post_start: start=%b busy=%b pulses=%0d, required 0 1 1", name, start, busy, start_cnt - s0);
        end
    endtask

    task automatic fft_cycle(input string name);
        repeat (100) @(posedge clk);
        #1 fft_done = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_done_hi: busy=%b, required 1", name, busy);
        end
        repeat (32) @(posedge clk);
        #1 fft_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || load !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_fall: busy=%b load=%b, required 1 0", name, busy, load);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b load=%b, required 0 0", name, busy, load);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({load, start, busy, overrun} !== 4'b0000 || rd !== 16'h0) begin
            errors++;
            $display("FAIL reset: load=%b start=%b busy=%b overrun=%b rd=%h, required all 0",
                     load, start, busy, overrun, rd);
        end
    endtask

    task automatic test_single_frame;
        for (int k = 0; k < 32; k++) send({k[15:0], 8'hAB}, k[15:0], 1'b1, k == 31 ? 1 : 8);
        @(negedge clk);
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: load=%b, required 0", load);
        end
        @(negedge clk);
        checks++;
        if (load !== 1'b1) begin
            errors++;
            $display("FAIL latency: load=%b, required 1 two cycles after frame end", load);
        end
        collect_frame("single");
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL single_overrun: overrun=%b, required 0", overrun);
        end
        fft_cycle("single_fft");
    endtask

    task automatic test_negative;
        send(24'hFFF000, 16'hFFF0, 1'b1, 2);
        send(24'h800000, 16'h8000, 1'b1, 2);
        for (int k = 2; k < 32; k++) send({8'hC0 | k[7:0], 16'h00FF}, {8'hC0 | k[7:0], 8'h00}, 1'b1, k == 31 ? 1 : 2);
        @(negedge clk);
        collect_frame("negative");
        fft_cycle("negative_fft");
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 32; k++) send({k[15:0], 8'h11}, k[15:0], 1'b1, k == 31 ? 1 : 2);
        @(negedge clk);
        collect_frame("b2b_first");
        fork
            for (int k = 32; k < 64; k++) send({k[15:0], 8'h22}, k[15:0], 1'b1, 2);
            begin
                repeat (100) @(posedge clk);
                #1 fft_done = 1'b1;
                repeat (32) @(posedge clk);
                #1 fft_done = 1'b0;
            end
        join
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: load=%b busy=%b, required 0 1", load, busy);
        end
        @(negedge clk);
        checks++;
        if (load !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: load=%b, required 1 the cycle after fft_done falls", load);
        end
        collect_frame("b2b_second");
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: overrun=%b, required 0", overrun);
        end
        fft_cycle("b2b_fft");
    endtask

    task automatic test_overrun;
        int s0;
        for (int k = 0; k < 32; k++) send({k[15:0], 8'h33}, k[15:0], 1'b1, k == 31 ? 1 : 2);
        @(negedge clk);
        collect_frame("ovr_first");
        s0 = start_cnt;
        for (int k = 32; k < 64; k++) send({k[15:0], 8'h44}, k[15:0], 1'b1, 2);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_frame2: overrun=%b, required 0", overrun);
        end
        for (int k = 64; k < 96; k++) send({k[15:0], 8'h55}, k[15:0], 1'b0, 2);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_frame3: overrun=%b, required 1", overrun);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (start_cnt !== s0 || busy !== 1'b1 || load !== 1'b0 || overrun !== 1'b1 || exp_q.size() !== 32) begin
            errors++;
            $display("FAIL ovr_stall: starts=%0d busy=%b load=%b overrun=%b queued=%0d, required %0d 1 0 1 32",
                     start_cnt, busy, load, overrun, exp_q.size(), s0);
        end
    endtask

    task automatic test_reset_mid_load;
        int w;
        test_reset();
        exp_q.delete();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_overrun_clear: overrun=%b, required 0", overrun);
        end
        for (int k = 0; k < 32; k++) send({16'h4000 + k[15:0], 8'h00}, 16'h4000 + k[15:0], 1'b0, k == 31 ? 1 : 2);
        w = 0;
        while (load !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (9) @(negedge clk);
        checks++;
        if (load !== 1'b1 || rd !== 16'h4009) begin
            errors++;
            $display("FAIL mid_load10: load=%b rd=%h, required 1 4009", load, rd);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({load, start, busy} !== 3'b000 || rd !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: load=%b start=%b busy=%b rd=%h, required 0 0 0 0000", load, start, busy, rd);
        end
        for (int k = 0; k < 32; k++) send({16'h7000 + k[15:0], 8'h66}, 16'h7000 + k[15:0], 1'b1, k == 31 ? 1 : 2);
        @(negedge clk);
        collect_frame("post_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_negative();
        test_back_to_back();
        test_overrun();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
